// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl: CBC/ECB block-chaining wrapper around a level-started DES core.
//   Plaintext arrives on a valid/ready stream. It is XORed with the chain value,
//   which is the IV or the previous ciphertext. The block is then handed to the
//   core with a held start. After the core reports ready, start is released and
//   the result is presented on an output valid/ready stream.
// Build option: define DES_CBC_EN to enable CBC chaining. With the macro
//   undefined the block runs in ECB mode: no chaining and iv_in ignored.
module des_cbc_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iv_load,
    input  logic [1:64] iv_in,
    input  logic [1:64] key_in,
    input  logic        in_valid,
    input  logic [1:64] in_data,
    output logic        in_ready,
    output logic        core_start,
    output logic [1:64] core_din,
    output logic [1:64] core_key,
    input  logic        core_ready,
    input  logic [1:64] core_dout,
    output logic        out_valid,
    output logic [1:64] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RELEASE,
        S_OUTPUT
    } state_t;

    // Last watchdog value allowed in WAIT before giving up on the core.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [1:64] key_r;
    logic [1:64] din_r;
    logic [1:64] dout_r;
    logic [7:0]  wdog;
    logic [1:64] blk_mixed;

    // A pending iv_load takes priority over a waiting block, so the block is
    // held off for that cycle and picks up the new IV on the next one.
    assign in_ready = (state == S_IDLE) && !iv_load;

    assign core_din = din_r;
    assign core_key = key_r;
    assign out_data = dout_r;

`ifdef DES_CBC_EN
    logic [1:64] chain_r;

    assign blk_mixed = in_data ^ chain_r;

    // Chain value: loaded from the IV, then replaced by each captured ciphertext.
    // A watchdog abort leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= '0;
        end else if (state == S_IDLE && iv_load) begin
            chain_r <= iv_in;
        end else if (state == S_WAIT && core_ready) begin
            chain_r <= core_dout;
        end
    end
`else
    logic unused_iv;

    // ECB: blocks go to the core unmodified and the IV has no effect.
    assign blk_mixed = in_data;
    assign unused_iv = ^iv_in;
`endif

    // Controller FSM. All stream/core control outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            core_start  <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            wdog        <= '0;
            key_r       <= '0;
            din_r       <= '0;
            dout_r      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iv_load) begin
                        key_r       <= key_in;
                        err_timeout <= 1'b0;
                    end else if (in_valid) begin
                        din_r      <= blk_mixed;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    wdog <= wdog + 8'd1;
                    if (core_ready) begin
                        dout_r     <= core_dout;
                        core_start <= 1'b0;
                        state      <= S_RELEASE;
                    end else if (wdog == WDOG_LAST) begin
                        err_timeout <= 1'b1;
                        core_start  <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_RELEASE: begin
                    // Hold here until the core has dropped ready, so its DONE
                    // state cannot be mistaken for the next block's result.
                    if (!core_ready) begin
                        out_valid <= 1'b1;
                        state     <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    core_start <= 1'b0;
                    out_valid  <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Bench for des_cbc_ctrl: a stub core with programmable latency, stuck and
// spurious-ready modes; a scoreboard of expected ciphertexts checked at each
// output handshake; directed steps covering reset, chaining, backpressure,
// watchdog, iv_load/in_valid collision and reset mid-operation.
module tb_des_cbc_ctrl;

    localparam int TB_TIMEOUT = 8;
    localparam int STUB_LAT   = 3;

    localparam logic [1:64] KEY  = 64'h133457799BBCDFF1;
    localparam logic [1:64] PT1  = 64'h0123456789ABCDEF;
    localparam logic [1:64] PT2  = 64'hFEDCBA9876543210;
    localparam logic [1:64] PT3  = 64'h00FF00FF12345678;
    localparam logic [1:64] IV2  = 64'hDEADBEEFCAFEF00D;
    localparam logic [1:64] FIPS = 64'h85E813540F0AB405;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv_load;
    logic [1:64] iv_in;
    logic [1:64] key_in;
    logic        in_valid;
    logic [1:64] in_data;
    logic        in_ready;
    logic        core_start;
    logic [1:64] core_din;
    logic [1:64] core_key;
    logic        core_ready;
    logic [1:64] core_dout;
    logic        out_valid;
    logic [1:64] out_data;
    logic        out_ready;
    logic        busy;
    logic        err_timeout;

    int n_chk  = 0;
    int n_pass = 0;

    logic [1:64] sb[$];
    logic [1:64] got[$];
    logic [1:64] m_chain = '0;
    logic [1:64] m_key   = '0;

    logic stub_stuck = 1'b0;
    logic stub_force = 1'b0;
    logic ready_q;
    int   stub_cnt;

    des_cbc_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .iv_load(iv_load), .iv_in(iv_in), .key_in(key_in),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .core_start(core_start), .core_din(core_din), .core_key(core_key),
        .core_ready(core_ready), .core_dout(core_dout),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: the FIPS reference pair, otherwise a keyed swap/XOR.
    function automatic logic [1:64] stub_enc(input logic [1:64] d, input logic [1:64] k);
        if (d == 64'h0123456789ABCDEF && k == 64'h133457799BBCDFF1)
            return 64'h85E813540F0AB405;
        return {d[33:64], d[1:32]} ^ k ^ 64'hC3A596F01E2D4B78;
    endfunction

    // Stub core: counts STUB_LAT cycles of held start, then holds ready and the
    // result until start drops; ready falls one cycle after start falls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            stub_cnt  <= 0;
            core_dout <= '0;
        end else if (!core_start) begin
            ready_q  <= 1'b0;
            stub_cnt <= 0;
        end else if (!stub_stuck && !ready_q) begin
            if (stub_cnt == STUB_LAT - 1) begin
                ready_q   <= 1'b1;
                core_dout <= stub_enc(core_din, core_key);
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end
    assign core_ready = ready_q | stub_force;

    task automatic chk(input string tag, input logic [1:64] obs, input logic [1:64] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    endtask

    // Output side of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk_b("spurious_out", out_valid, 1'b0);
            else begin
                chk("out_data", out_data, sb.pop_front());
                got.push_back(out_data);
            end
        end
    end

    task automatic load(input logic [1:64] iv, input logic [1:64] k);
        iv_load = 1'b1; iv_in = iv; key_in = k;
        @(posedge clk); #1;
        iv_load = 1'b0;
        m_key = k;
`ifdef DES_CBC_EN
        m_chain = iv;
`endif
        chk("core_key", core_key, k);
    endtask

    // Offer one block; expect_out=0 means the core is expected not to answer.
    task automatic send(input logic [1:64] pt, input bit expect_out);
        int n;
        logic acc;
        logic [1:64] e;
        n = 0; acc = 1'b0;
        in_valid = 1'b1; in_data = pt;
        while (!acc && n < 200) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); n++;
        end
        #1; in_valid = 1'b0;
        chk_b("accept", acc, 1'b1);
        chk("core_din", core_din, pt ^ m_chain);
        if (expect_out) begin
            e = stub_enc(pt ^ m_chain, m_key);
            sb.push_back(e);
`ifdef DES_CBC_EN
            m_chain = e;
`endif
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk_b("drain", (sb.size() == 0) && !busy, 1'b1);
    endtask

    initial begin
        int n;
        int k;
        logic [1:64] first;
        rst_n = 1'b0; iv_load = 1'b0; iv_in = '0; key_in = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #2;
        // Reset values
        chk_b("rst_in_ready", in_ready, 1'b1);
        chk_b("rst_core_start", core_start, 1'b0);
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_err", err_timeout, 1'b0);
        chk("rst_core_key", core_key, 64'h0);
        chk("rst_core_din", core_din, 64'h0);
        chk("rst_out_data", out_data, 64'h0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;

        // core_ready while idle must not start anything
        stub_force = 1'b1;
        repeat (2) @(posedge clk);
        #1; stub_force = 1'b0;
        chk_b("spur_busy", busy, 1'b0);
        chk_b("spur_out_valid", out_valid, 1'b0);

        // FIPS vector with zero IV
        load(64'h0, KEY);
        send(PT1, 1'b1);
        drain();
        first = got[got.size() - 1];
        chk("fips_out", first, FIPS);
        chk_b("fips_err", err_timeout, 1'b0);

        // Same block again: chained in CBC, identical in ECB
        send(PT1, 1'b1);
        drain();
`ifdef DES_CBC_EN
        chk_b("cbc_differs", got[got.size() - 1] != first, 1'b1);
`else
        chk("ecb_same", got[got.size() - 1], first);
`endif

        // Output backpressure for 20 cycles
        out_ready = 1'b0;
        send(PT2, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk_b("bp_reach", out_valid, 1'b1);
        for (int i = 0; i < 20; i++) begin
            chk_b("bp_valid", out_valid, 1'b1);
            chk("bp_data", out_data, sb[0]);
            chk_b("bp_in_ready", in_ready, 1'b0);
            chk_b("bp_start", core_start, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();

        // Watchdog: core never answers
        stub_stuck = 1'b1;
        send(PT3, 1'b0);
        n = 0; k = 0;
        while (busy && k < 100) begin
            if (core_start) n++;
            @(posedge clk); #1; k++;
        end
        chk("wdog_start_cycles", 64'(n), 64'(TB_TIMEOUT + 1));
        chk_b("wdog_err", err_timeout, 1'b1);
        chk_b("wdog_busy", busy, 1'b0);
        chk_b("wdog_start", core_start, 1'b0);
        chk_b("wdog_no_out", out_valid, 1'b0);
        stub_stuck = 1'b0;
        send(PT3, 1'b1);
        drain();
        chk_b("wdog_err_sticky", err_timeout, 1'b1);
        load(IV2, KEY);
        chk_b("wdog_err_clear", err_timeout, 1'b0);

        // iv_load and in_valid together: load wins, block taken next cycle
        iv_load = 1'b1; iv_in = 64'h0F1E2D3C4B5A6978; key_in = KEY;
        in_valid = 1'b1; in_data = PT2;
        @(negedge clk);
        chk_b("simul_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        iv_load = 1'b0;
        m_key = KEY;
`ifdef DES_CBC_EN
        m_chain = 64'h0F1E2D3C4B5A6978;
`endif
        chk_b("simul_not_taken", busy, 1'b0);
        send(PT2, 1'b1);
        drain();

        // Reset three cycles into WAIT
        stub_stuck = 1'b1;
        send(PT1, 1'b0);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        chk_b("mid_rst_start", core_start, 1'b0);
        chk_b("mid_rst_busy", busy, 1'b0);
        chk_b("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_key", core_key, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; stub_stuck = 1'b0;
        m_chain = '0; m_key = '0;
        send(PT1, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/des_cbc_ctrl.md
# des_cbc_ctrl

Block-chaining controller that sits directly upstream and downstream of the `des` core. It accepts 64-bit plaintext blocks over a valid/ready stream and XORs each with the IV or the previous ciphertext. It then drives the core's level-held `start`, waits for `ready`, releases the core back to idle, and presents the ciphertext on an output valid/ready stream.

## Interface
- `TIMEOUT`, default 64: maximum cycles to wait for `core_ready` after `core_start` rises; 8-bit counter, legal range 1–255.
- `clk` input 1: clock, all logic rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `iv_load` input 1: pulse; loads `iv_in` and `key_in`, accepted only in IDLE.
- `iv_in` input [1:64]: initialisation vector; bit 1 is MSB.
- `key_in` input [1:64]: DES key, latched with `iv_load`.
- `in_valid` input 1: plaintext block valid.
- `in_data` input [1:64]: plaintext block.
- `in_ready` output 1: block accepted when `in_valid && in_ready`.
- `core_start` output 1: to `des.start`, held high for the whole operation.
- `core_din` output [1:64]: to `des.desIn`, registered.
- `core_key` output [1:64]: to `des.keyIn`, registered.
- `core_ready` input 1: from `des.ready`.
- `core_dout` input [1:64]: from `des.desOut`.
- `out_valid` output 1: ciphertext valid.
- `out_data` output [1:64]: ciphertext, registered.
- `out_ready` input 1: downstream accepts when `out_valid && out_ready`.
- `busy` output 1: high in any state other than IDLE.
- `err_timeout` output 1: sticky; set on watchdog expiry, cleared by `iv_load`.

## Operation
- Registers: `chain_r` [1:64], `key_r` [1:64], `din_r`, `dout_r`, `wdog` [7:0], `state`.
- States: IDLE, LAUNCH, WAIT, RELEASE, OUTPUT.
- IDLE:
  - `in_ready` = 1.
  - `iv_load` sets `chain_r` <= `iv_in`, `key_r` <= `key_in` and clears `err_timeout`.
  - On an accepted block: `din_r` <= `in_data ^ chain_r`, go to LAUNCH.
  - If `iv_load` and `in_valid` are both asserted, `iv_load` wins, `in_ready` is forced 0 that cycle, and the block waits.
- LAUNCH: assert `core_start`, clear `wdog`, go to WAIT.
- WAIT:
  - `core_start` held 1 and `wdog` increments.
  - On `core_ready` = 1: `dout_r` <= `core_dout`, `chain_r` <= `core_dout`, go to RELEASE.
  - If `wdog == TIMEOUT-1` and `core_ready` = 0: set `err_timeout`, drop `core_start`, go to IDLE. `chain_r` is unchanged and no output is produced.
- RELEASE:
  - `core_start` = 0; stay until `core_ready` = 0, so the core has left DONE.
  - Then go to OUTPUT, minimum one cycle in RELEASE.
- OUTPUT:
  - `out_valid` = 1 and `out_data` = `dout_r`, held stable until `out_ready`.
  - On handshake go to IDLE.
- `core_key` is driven from `key_r` continuously and changes only in IDLE.
- All XOR is 64-bit bitwise with no carries; bit n of the input XORs with bit n of the chain.

## Timing
- Reset values:
  - State IDLE; `in_ready` = 1; `core_start` = 0; `out_valid` = 0; `busy` = 0; `err_timeout` = 0.
  - All data registers 0, including `chain_r` (zero IV) and `key_r`.
- Input handshake to `core_start` high: 1 cycle.
- Core-side turnaround: `core_start` high until the first cycle with `core_ready`; ciphertext is captured on that edge.
- `core_ready` sampled high to `out_valid`: 2 cycles minimum (RELEASE plus one cycle for the core to leave DONE).
- Back-to-back throughput: one block per core latency + 4 cycles, assuming `out_ready` is held 1.
- `in_ready` is 0 from the acceptance edge until OUTPUT completes; there is no input buffering.
- Reset mid-operation: `core_start` falls asynchronously and all state returns to reset values. The core is reset on the same `rst_n`.
- `core_ready` asserting in IDLE, LAUNCH or OUTPUT is ignored.

## Configuration
- `DES_CBC_EN` defined:
  - CBC chaining as described above.
- `DES_CBC_EN` undefined (ECB mode):
  - `din_r` <= `in_data`; `chain_r` is not updated.
  - `iv_in` is ignored and `iv_load` loads only the key and clears `err_timeout`.
  - All state machine and timing behaviour is identical.

## Test plan
- FIPS vector: `iv_load` with IV = 0 and key 0x133457799BBCDFF1, then block 0x0123456789ABCDEF -> `out_data` = 0x85E813540F0AB405, `err_timeout` = 0.
- CBC chain with IV = 0, same key, two identical blocks 0x0123456789ABCDEF -> second `out_data` equals DES(0x0123456789ABCDEF ^ 0x85E813540F0AB405) and differs from the first. Without `DES_CBC_EN` the two outputs must be identical.
- Output backpressure: hold `out_ready` = 0 for 20 cycles -> `out_valid` and `out_data` stay stable, `in_ready` = 0, `core_start` = 0 throughout.
- Watchdog: stub core with `core_ready` stuck 0 and `TIMEOUT` = 8 -> `core_start` falls after 8 WAIT cycles, `err_timeout` = 1, back to IDLE. A following `iv_load` clears `err_timeout`.
- Reset mid-WAIT: assert `rst_n` = 0 three cycles into WAIT -> `core_start`, `busy` and `out_valid` are 0 immediately. After release, the first block encrypts with IV = 0.
- Simultaneous `iv_load` and `in_valid` in IDLE -> IV loads, block not accepted that cycle; it is accepted next cycle using the new IV.
